gray_ptr_sync_rx: RTL and testbench

//  Receive side of a multi-bit CDC path. Takes a Gray-coded pointer launched from
//  a foreign clock domain and runs it through an N-flop synchroniser in the local

---
 rtl/gray_ptr_sync_rx.sv | 111 +++++++++++
 tb/tb_gray_ptr_sync_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_sync_rx.sv
// Receive side of a Gray-coded pointer CDC path: N-flop synchroniser, Gray-to-binary
// conversion, advance detection. Optional Gray multi-bit-change check: GRAY_PTR_ERR_CHK_EN.
module gray_ptr_sync_rx #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_sync,
    output logic [WIDTH-1:0] bin_out,
    output logic             ptr_valid,
    output logic             ptr_chg,
    output logic [WIDTH-1:0] delta,
    output logic             gray_err
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;

    // Plain flop chain, nothing between stages
    always_comb begin
        sync_d[0] = gray_in;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign gray_sync = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits at or above i
    always_comb begin
        bin_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_d[i] = ^(gray_sync >> i);
        end
    end

    always_comb begin
        cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        valid_d = (cnt_d == CNT_SAT);
        chg_d   = valid_q && (bin_d != bin_q);
        delta_d = chg_d ? WIDTH'(bin_d - bin_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            bin_q   <= '0;
            delta_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            bin_q   <= bin_d;
            delta_q <= delta_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
        end
    end

    assign bin_out   = bin_q;
    assign ptr_valid = valid_q;
    assign ptr_chg   = chg_q;
    assign delta     = delta_q;

`ifdef GRAY_PTR_ERR_CHK_EN
    localparam int unsigned POP_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [POP_W-1:0] pop_c;
    logic             err_q, err_d;

    // A legal Gray step flips exactly one bit; more than one means a broken source
    always_comb begin
        pop_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop_c = pop_c + POP_W'(gray_sync[i] ^ prev_q[i]);
        end
        prev_d = gray_sync;
        err_d  = err_q | (valid_q && (pop_c > POP_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign gray_err = err_q;
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_rx.sv
// Directed bench for gray_ptr_sync_rx: default (4,2) instance plus a (6,3) instance.
module tb_gray_ptr_sync_rx;

`ifdef GRAY_PTR_ERR_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gray_in;
    logic [3:0] gray_sync, bin_out, delta;
    logic       ptr_valid, ptr_chg, gray_err;

    logic [5:0] gray_in6;
    logic [5:0] gray_sync6, bin_out6, delta6;
    logic       ptr_valid6, ptr_chg6, gray_err6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_ptr_sync_rx #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_sync(gray_sync),
        .bin_out(bin_out), .ptr_valid(ptr_valid), .ptr_chg(ptr_chg),
        .delta(delta), .gray_err(gray_err)
    );

    gray_ptr_sync_rx #(.WIDTH(6), .SYNC_STAGES(3)) dut6 (
        .clk(clk), .rst(rst), .gray_in(gray_in6), .gray_sync(gray_sync6),
        .bin_out(bin_out6), .ptr_valid(ptr_valid6), .ptr_chg(ptr_chg6),
        .delta(delta6), .gray_err(gray_err6)
    );

    function automatic logic [3:0] g4(input int unsigned b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [5:0] g6(input int unsigned b);
        logic [5:0] v;
        v = 6'(b);
        return v ^ (v >> 1);
    endfunction

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] g, input logic [5:0] g6v);
        gray_in  = g;
        gray_in6 = g6v;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        gray_in  = 4'b1010;
        gray_in6 = '0;
        rst = 1'b1;
        repeat (3) tick();
        checks += 6;
        if (gray_sync !== 4'd0) begin errors++; $display("FAIL rst_gray_sync: got %0d exp 0", gray_sync); end
        if (bin_out !== 4'd0)   begin errors++; $display("FAIL rst_bin_out: got %0d exp 0", bin_out); end
        if (ptr_valid !== 1'b0) begin errors++; $display("FAIL rst_ptr_valid: got %0b exp 0", ptr_valid); end
        if (ptr_chg !== 1'b0)   begin errors++; $display("FAIL rst_ptr_chg: got %0b exp 0", ptr_chg); end
        if (delta !== 4'd0)     begin errors++; $display("FAIL rst_delta: got %0d exp 0", delta); end
        if (gray_err !== 1'b0)  begin errors++; $display("FAIL rst_gray_err: got %0b exp 0", gray_err); end
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks += 2;
            if (ptr_valid !== (e == 3)) begin
                errors++; $display("FAIL startup_valid edge %0d: got %0b exp %0b", e, ptr_valid, e == 3);
            end
            if (ptr_chg !== 1'b0) begin
                errors++; $display("FAIL startup_chg edge %0d: got %0b exp 0", e, ptr_chg);
            end
        end
        checks += 3;
        if (bin_out !== 4'd12)     begin errors++; $display("FAIL startup_bin: got %0d exp 12", bin_out); end
        if (gray_sync !== 4'b1010) begin errors++; $display("FAIL startup_gray_sync: got %0d exp 10", gray_sync); end
        if (gray_err !== 1'b0)     begin errors++; $display("FAIL startup_err: got %0b exp 0", gray_err); end
    endtask

    task automatic test_walk();
        logic [3:0] prev_b;
        do_reset(4'd0, 6'd0);
        prev_b = 4'd0;
        for (int s = 1; s <= 16; s++) begin
            gray_in = g4(s % 16);
            repeat (2) tick();
            checks += 2;
            if (bin_out !== prev_b) begin errors++; $display("FAIL walk_early_bin step %0d: got %0d exp %0d", s, bin_out, prev_b); end
            if (ptr_chg !== 1'b0)   begin errors++; $display("FAIL walk_early_chg step %0d: got %0b exp 0", s, ptr_chg); end
            tick();
            checks += 3;
            if (bin_out !== 4'(s % 16)) begin errors++; $display("FAIL walk_bin step %0d: got %0d exp %0d", s, bin_out, s % 16); end
            if (ptr_chg !== 1'b1)   begin errors++; $display("FAIL walk_chg step %0d: got %0b exp 1", s, ptr_chg); end
            if (delta !== 4'd1)     begin errors++; $display("FAIL walk_delta step %0d: got %0d exp 1", s, delta); end
            tick();
            checks += 2;
            if (ptr_chg !== 1'b0)   begin errors++; $display("FAIL walk_pulse step %0d: got %0b exp 0", s, ptr_chg); end
            if (delta !== 4'd0)     begin errors++; $display("FAIL walk_delta_clr step %0d: got %0d exp 0", s, delta); end
            prev_b = 4'(s % 16);
        end
        checks++;
        if (gray_err !== 1'b0) begin errors++; $display("FAIL walk_err: got %0b exp 0", gray_err); end
    endtask

    task automatic test_hold();
        do_reset(4'b0111, 6'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            checks += 3;
            if (ptr_chg !== 1'b0) begin errors++; $display("FAIL hold_chg cycle %0d: got %0b exp 0", c, ptr_chg); end
            if (delta !== 4'd0)   begin errors++; $display("FAIL hold_delta cycle %0d: got %0d exp 0", c, delta); end
            if (bin_out !== 4'd5) begin errors++; $display("FAIL hold_bin cycle %0d: got %0d exp 5", c, bin_out); end
        end
    endtask

    task automatic test_jump();
        do_reset(4'b0000, 6'd0);
        gray_in = 4'b0011;
        repeat (3) tick();
        checks += 4;
        if (ptr_chg !== 1'b1)     begin errors++; $display("FAIL jump_chg: got %0b exp 1", ptr_chg); end
        if (delta !== 4'd2)       begin errors++; $display("FAIL jump_delta: got %0d exp 2", delta); end
        if (bin_out !== 4'd2)     begin errors++; $display("FAIL jump_bin: got %0d exp 2", bin_out); end
        if (gray_err !== ERR_EXP) begin errors++; $display("FAIL jump_err: got %0b exp %0b", gray_err, ERR_EXP); end
        repeat (6) tick();
        checks++;
        if (gray_err !== ERR_EXP) begin errors++; $display("FAIL jump_err_sticky: got %0b exp %0b", gray_err, ERR_EXP); end
    endtask

    task automatic test_mid_reset();
        do_reset(4'b1101, 6'd0);
        checks += 2;
        if (bin_out !== 4'd9)   begin errors++; $display("FAIL mid_pre_bin: got %0d exp 9", bin_out); end
        if (ptr_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b exp 1", ptr_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 4;
        if (bin_out !== 4'd0)   begin errors++; $display("FAIL mid_bin: got %0d exp 0", bin_out); end
        if (ptr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b exp 0", ptr_valid); end
        if (gray_sync !== 4'd0) begin errors++; $display("FAIL mid_gray_sync: got %0d exp 0", gray_sync); end
        if (gray_err !== 1'b0)  begin errors++; $display("FAIL mid_err: got %0b exp 0", gray_err); end
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks += 3;
            if (ptr_valid !== (e >= 3)) begin errors++; $display("FAIL mid_valid edge %0d: got %0b exp %0b", e, ptr_valid, e >= 3); end
            if (ptr_chg !== 1'b0)  begin errors++; $display("FAIL mid_chg edge %0d: got %0b exp 0", e, ptr_chg); end
            if (gray_err !== 1'b0) begin errors++; $display("FAIL mid_err edge %0d: got %0b exp 0", e, gray_err); end
        end
        checks++;
        if (bin_out !== 4'd9) begin errors++; $display("FAIL mid_post_bin: got %0d exp 9", bin_out); end
    endtask

    task automatic test_param();
        gray_in6 = g6(62);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (ptr_valid6 !== (e == 4)) begin errors++; $display("FAIL p6_valid edge %0d: got %0b exp %0b", e, ptr_valid6, e == 4); end
        end
        checks++;
        if (bin_out6 !== 6'd62) begin errors++; $display("FAIL p6_settle_bin: got %0d exp 62", bin_out6); end
        for (int s = 0; s < 2; s++) begin
            logic [5:0] tgt;
            logic [5:0] prev;
            tgt  = (s == 0) ? 6'd63 : 6'd0;
            prev = (s == 0) ? 6'd62 : 6'd63;
            gray_in6 = g6(tgt);
            repeat (3) tick();
            checks += 2;
            if (bin_out6 !== prev) begin errors++; $display("FAIL p6_latency_bin %0d: got %0d exp %0d", s, bin_out6, prev); end
            if (ptr_chg6 !== 1'b0) begin errors++; $display("FAIL p6_latency_chg %0d: got %0b exp 0", s, ptr_chg6); end
            tick();
            checks += 3;
            if (bin_out6 !== tgt)  begin errors++; $display("FAIL p6_bin %0d: got %0d exp %0d", s, bin_out6, tgt); end
            if (ptr_chg6 !== 1'b1) begin errors++; $display("FAIL p6_chg %0d: got %0b exp 1", s, ptr_chg6); end
            if (delta6 !== 6'd1)   begin errors++; $display("FAIL p6_delta %0d: got %0d exp 1", s, delta6); end
        end
        checks++;
        if (gray_err6 !== 1'b0) begin errors++; $display("FAIL p6_err: got %0b exp 0", gray_err6); end
    endtask

    initial begin
        rst      = 1'b1;
        gray_in  = '0;
        gray_in6 = '0;
        #1;
        test_reset();
        test_walk();
        test_hold();
        test_jump();
        test_mid_reset();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
